linebuf_ctrl: RTL and testbench
===============================

LINEBUF_CTRL -- requirements
Module: linebuf_ctrl

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 80, meaning the number of 8-pixel words per scanline (1..512).
REQ-002 SHALL have parameter BG_COLOUR, default 9'h000, meaning the clear colour, replicated 8x onto colour_on_draw.
REQ-003 SHALL have port clk_draw, input, 1 bit: the single clock; reset is synchronous and active-high.
REQ-004 SHALL have port rst_draw, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port line_start, input, 1 bit: one-cycle pulse marking the start of a new scanline, already in the draw domain.
REQ-006 SHALL have port scan_word, input, 9 bits: reader word position, draw-domain synchronized, monotonic non-decreasing within a line.
REQ-007 SHALL have port draw_done, input, 1 bit: drawer pulse meaning the off-screen line is complete.
REQ-008 SHALL have inputs wr_valid (1 bit), wr_addr (9 bits), wr_mask (8 bits) and wr_colour (72 bits): the drawer write request.
REQ-009 SHALL have port wr_ready, output, 1 bit: write accepted when wr_valid && wr_ready.
REQ-010 SHALL have port draw_start, output, 1 bit: one-cycle pulse telling the drawer to render a new line.
REQ-011 SHALL have port buffsel_draw, output, 1 bit: draw-domain buffer select.
REQ-012 SHALL have outputs addr_on_draw (9 bits), we_on_draw (1 bit) and colour_on_draw (72 bits): the clear port.
REQ-013 SHALL have outputs addr_off_draw (9 bits), we_off_draw (8 bits) and colour_off_draw (72 bits): the off-screen write port.
REQ-014 SHALL have outputs overrun and clr_err, 1 bit each: one-cycle error pulses.

Function
REQ-015 SHALL implement a draw FSM with states IDLE, DRAW and WAIT.
REQ-016 SHALL, on line_start in any state, toggle buffsel_draw and assert draw_start for exactly one cycle on the following cycle; the FSM then enters DRAW.
REQ-017 SHALL, on line_start while in DRAW, also pulse overrun in the same cycle as the flip.
REQ-018 SHALL, on draw_done while in DRAW without a coincident line_start, go from DRAW to WAIT; draw_done in IDLE or WAIT is ignored.
REQ-019 SHALL, when line_start and draw_done coincide in DRAW, let line_start win: flip, pulse overrun, stay in DRAW.
REQ-020 SHALL drive wr_ready = 1 only in DRAW, and not in the flip cycle.
REQ-021 SHALL, on an accepted write, drive addr_off_draw, we_off_draw = wr_mask and colour_off_draw one cycle later, one-stage registered; we_off_draw is 0 otherwise.
REQ-022 SHALL implement a clear FSM with states CLR_IDLE and CLR_RUN and a 9-bit clear pointer.
REQ-023 SHALL, on each flip, zero the pointer and enter CLR_RUN.
REQ-024 SHALL, in CLR_RUN, assert we_on_draw with addr_on_draw = pointer and colour_on_draw = 8x BG_COLOUR, and increment the pointer, only when pointer < scan_word; otherwise we_on_draw is 0 and the pointer holds.
REQ-025 SHALL return to CLR_IDLE after writing word LINE_WORDS-1; at most one word is cleared per cycle.
REQ-026 SHALL, on line_start while still in CLR_RUN, pulse clr_err, then restart per REQ-023.
REQ-027 SHALL never let clear addresses exceed LINE_WORDS-1, even if scan_word > LINE_WORDS.

Reset
REQ-028 SHALL, on rst_draw, set the draw FSM to IDLE, the clear FSM to CLR_IDLE, the pointer to 0 and buffsel_draw to 0.
REQ-029 SHALL, on rst_draw, drive draw_start, wr_ready, we_on_draw, we_off_draw (8'h00), overrun and clr_err to 0, and addr/colour outputs to 0.
REQ-030 SHALL, when reset is asserted mid-line, abort any pending registered write and any clear without generating errors.
REQ-031 SHALL, on the first line_start after reset, set buffsel_draw to 1.

Configuration
REQ-032 SHALL, with LINEBUF_OVERRUN_CNT_EN defined, add output overrun_cnt (16 bits), reset to 0, which increments on each overrun pulse and saturates at 16'hFFFF.
REQ-033 SHALL, with LINEBUF_OVERRUN_CNT_EN undefined, have no overrun_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-034 SHALL cover: reset, then line_start at cycle 5 -> buffsel_draw=1 at cycle 6, draw_start high at cycle 6 only, wr_ready=1 from cycle 7.
REQ-035 SHALL cover: in DRAW, wr_valid with wr_addr=9'd3, wr_mask=8'h0F, wr_colour=X -> next cycle addr_off_draw=3, we_off_draw=8'h0F, colour_off_draw=X.
REQ-036 SHALL cover: after a flip, scan_word held at 0 for 10 cycles then set to 80 -> no we_on_draw for those 10 cycles, then 80 consecutive clears at addresses 0..79, then CLR_IDLE.
REQ-037 SHALL cover: line_start while in DRAW -> overrun pulses 1 cycle, buffsel_draw toggles, draw_start re-pulses; with macro defined, overrun_cnt = 1.
REQ-038 SHALL cover: line_start while the clear pointer = 40 -> clr_err pulses, pointer restarts at 0.
REQ-039 SHALL cover: line_start and draw_done in the same cycle during DRAW -> overrun=1, FSM remains DRAW.

Source files
------------

// File: rtl/linebuf_ctrl.sv
// linebuf_ctrl: double-buffered scanline draw/clear controller; define LINEBUF_OVERRUN_CNT_EN for the overrun_cnt output.
module linebuf_ctrl #(
  parameter int         LINE_WORDS = 80,
  parameter logic [8:0] BG_COLOUR  = 9'h000
) (
  input  logic        clk_draw,
  input  logic        rst_draw,
  input  logic        line_start,
  input  logic [8:0]  scan_word,
  input  logic        draw_done,
  input  logic        wr_valid,
  input  logic [8:0]  wr_addr,
  input  logic [7:0]  wr_mask,
  input  logic [71:0] wr_colour,
  output logic        wr_ready,
  output logic        draw_start,
  output logic        buffsel_draw,
  output logic [8:0]  addr_on_draw,
  output logic        we_on_draw,
  output logic [71:0] colour_on_draw,
  output logic [8:0]  addr_off_draw,
  output logic [7:0]  we_off_draw,
  output logic [71:0] colour_off_draw,
  output logic        overrun,
  output logic        clr_err
`ifdef LINEBUF_OVERRUN_CNT_EN
  ,
  output logic [15:0] overrun_cnt
`endif
);
  localparam logic [1:0] S_IDLE = 2'd0, S_DRAW = 2'd1, S_WAIT = 2'd2;
  localparam logic [0:0] C_IDLE = 1'b0, C_RUN = 1'b1;
  localparam logic [8:0] LAST = 9'(LINE_WORDS - 1);
  logic [1:0]  state_q, state_d;
  logic [0:0]  clr_q, clr_d;
  logic [8:0]  ptr_q, ptr_d;
  logic        buffsel_q, buffsel_d, draw_start_q, draw_start_d;
  logic        overrun_q, overrun_d, clr_err_q, clr_err_d;
  logic [7:0]  we_off_q, we_off_d;
  logic [8:0]  addr_off_q, addr_off_d;
  logic [71:0] colour_off_q, colour_off_d;
  logic        clr_we, acc;
  // the clear trails the reader so it never wipes a word still to be displayed
  assign clr_we = (clr_q == C_RUN) && (ptr_q < scan_word);
  assign wr_ready = (state_q == S_DRAW) && !draw_start_q && !line_start;
  assign acc = wr_valid && wr_ready;
  always_comb begin
    state_d = line_start ? S_DRAW : (state_q == S_DRAW && draw_done) ? S_WAIT : state_q;
    buffsel_d = buffsel_q ^ line_start;
    draw_start_d = line_start;
    overrun_d = line_start && (state_q == S_DRAW);
    clr_err_d = line_start && (clr_q == C_RUN);
    clr_d = line_start ? C_RUN : (clr_we && ptr_q == LAST) ? C_IDLE : clr_q;
    ptr_d = line_start ? 9'd0 : (clr_we && ptr_q != LAST) ? ptr_q + 9'd1 : ptr_q;
    we_off_d = acc ? wr_mask : 8'h00;
    addr_off_d = acc ? wr_addr : addr_off_q;
    colour_off_d = acc ? wr_colour : colour_off_q;
  end
  always_ff @(posedge clk_draw) begin
    if (rst_draw) begin
      state_q <= S_IDLE;
      clr_q <= C_IDLE;
      ptr_q <= '0;
      buffsel_q <= 1'b0;
      draw_start_q <= 1'b0;
      overrun_q <= 1'b0;
      clr_err_q <= 1'b0;
      we_off_q <= '0;
      addr_off_q <= '0;
      colour_off_q <= '0;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      ptr_q <= ptr_d;
      buffsel_q <= buffsel_d;
      draw_start_q <= draw_start_d;
      overrun_q <= overrun_d;
      clr_err_q <= clr_err_d;
      we_off_q <= we_off_d;
      addr_off_q <= addr_off_d;
      colour_off_q <= colour_off_d;
    end
  end
  assign draw_start = draw_start_q;
  assign buffsel_draw = buffsel_q;
  assign overrun = overrun_q;
  assign clr_err = clr_err_q;
  assign addr_on_draw = ptr_q;
  assign we_on_draw = clr_we;
  assign colour_on_draw = clr_we ? {8{BG_COLOUR}} : 72'd0;
  assign addr_off_draw = addr_off_q;
  assign we_off_draw = we_off_q;
  assign colour_off_draw = colour_off_q;
`ifdef LINEBUF_OVERRUN_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = (overrun_d && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk_draw) begin
    if (rst_draw) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign overrun_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_linebuf_ctrl.sv
// tb_linebuf_ctrl: directed self-checking bench for linebuf_ctrl.
module tb_linebuf_ctrl;
  localparam logic [8:0] BG = 9'h1A5;
  logic        clk = 0, rst = 1, line_start = 0, draw_done = 0, wr_valid = 0;
  logic [8:0]  scan_word = 0, wr_addr = 0;
  logic [7:0]  wr_mask = 0;
  logic [71:0] wr_colour = 0;
  logic        wr_ready, draw_start, buffsel_draw, we_on_draw, overrun, clr_err;
  logic [8:0]  addr_on_draw, addr_off_draw;
  logic [7:0]  we_off_draw;
  logic [71:0] colour_on_draw, colour_off_draw;
  int total = 0, bad = 0, hits, n;
`ifdef LINEBUF_OVERRUN_CNT_EN
  logic [15:0] overrun_cnt;
`endif
  linebuf_ctrl #(.LINE_WORDS(80), .BG_COLOUR(BG)) dut (
    .clk_draw(clk), .rst_draw(rst), .line_start(line_start), .scan_word(scan_word),
    .draw_done(draw_done), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_mask(wr_mask),
    .wr_colour(wr_colour), .wr_ready(wr_ready), .draw_start(draw_start),
    .buffsel_draw(buffsel_draw), .addr_on_draw(addr_on_draw), .we_on_draw(we_on_draw),
    .colour_on_draw(colour_on_draw), .addr_off_draw(addr_off_draw), .we_off_draw(we_off_draw),
    .colour_off_draw(colour_off_draw), .overrun(overrun), .clr_err(clr_err)
`ifdef LINEBUF_OVERRUN_CNT_EN
    , .overrun_cnt(overrun_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    repeat (2) step();
    check("rst_buffsel", buffsel_draw, 0);
    check("rst_draw_start", draw_start, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_we_on", we_on_draw, 0);
    check("rst_we_off", we_off_draw, 0);
    check("rst_addr_off", addr_off_draw, 0);
    check("rst_colour_off", colour_off_draw, 0);
    check("rst_addr_on", addr_on_draw, 0);
    check("rst_colour_on", colour_on_draw, 0);
    check("rst_overrun", overrun, 0);
    check("rst_clr_err", clr_err, 0);
    rst = 0;
    repeat (4) step();
    line_start = 1;
    #1 check("idle_ready", wr_ready, 0);
    step();
    line_start = 0;
    #1;
    check("flip_buffsel", buffsel_draw, 1);
    check("flip_draw_start", draw_start, 1);
    check("flip_ready", wr_ready, 0);
    check("flip_overrun", overrun, 0);
    check("flip_clr_err", clr_err, 0);
    step();
    check("ds_one_cycle", draw_start, 0);
    check("draw_ready", wr_ready, 1);
    wr_valid = 1; wr_addr = 9'd3; wr_mask = 8'h0F; wr_colour = 72'h12_3456_789A_BCDE_F012;
    step();
    wr_valid = 0;
    check("off_addr", addr_off_draw, 3);
    check("off_we", we_off_draw, 8'h0F);
    check("off_colour", colour_off_draw, 72'h12_3456_789A_BCDE_F012);
    step();
    check("off_we_idle", we_off_draw, 0);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (we_on_draw) hits++;
    end
    check("clr_hold", hits, 0);
    scan_word = 9'd80;
    n = 0;
    for (int i = 0; i < 120; i++) begin
      #1;
      if (we_on_draw) begin
        check("clr_addr", addr_on_draw, n);
        if (n == 0) check("clr_colour", colour_on_draw, {8{BG}});
        n++;
      end
      step();
    end
    check("clr_count", n, 80);
    check("clr_done_we", we_on_draw, 0);
    check("clr_done_addr", addr_on_draw, 79);
    line_start = 1; scan_word = 9'd40;
    step();
    line_start = 0;
    #1;
    check("ovr_pulse", overrun, 1);
    check("ovr_buffsel", buffsel_draw, 0);
    check("ovr_draw_start", draw_start, 1);
    check("ovr_clr_err", clr_err, 0);
    step();
    check("ovr_one_cycle", overrun, 0);
    check("ovr_ds_one_cycle", draw_start, 0);
`ifdef LINEBUF_OVERRUN_CNT_EN
    check("ovr_cnt1", overrun_cnt, 1);
`endif
    repeat (45) step();
    check("stall_addr", addr_on_draw, 40);
    check("stall_we", we_on_draw, 0);
    line_start = 1;
    step();
    line_start = 0;
    #1;
    check("clrerr_pulse", clr_err, 1);
    check("clrerr_overrun", overrun, 1);
    check("clrerr_buffsel", buffsel_draw, 1);
    check("clrerr_restart", addr_on_draw, 0);
    check("clrerr_we", we_on_draw, 1);
    step();
    check("clrerr_one_cycle", clr_err, 0);
    check("clrerr_next", addr_on_draw, 1);
    line_start = 1; draw_done = 1;
    step();
    line_start = 0; draw_done = 0;
    #1;
    check("coin_overrun", overrun, 1);
    check("coin_buffsel", buffsel_draw, 0);
    step();
    check("coin_stay_draw", wr_ready, 1);
    draw_done = 1;
    step();
    draw_done = 0;
    #1 check("wait_ready", wr_ready, 0);
    draw_done = 1;
    step();
    draw_done = 0;
    #1 check("wait_ignore", wr_ready, 0);
    line_start = 1;
    step();
    line_start = 0;
    #1;
    check("wait_flip_overrun", overrun, 0);
    check("wait_flip_ds", draw_start, 1);
    check("wait_flip_buffsel", buffsel_draw, 1);
    step();
    check("wait_flip_ready", wr_ready, 1);
`ifdef LINEBUF_OVERRUN_CNT_EN
    check("ovr_cnt3", overrun_cnt, 3);
`endif
    wr_valid = 1; wr_addr = 9'd5; wr_mask = 8'hFF; rst = 1;
    step();
    wr_valid = 0;
    #1;
    check("mid_rst_we_off", we_off_draw, 0);
    check("mid_rst_we_on", we_on_draw, 0);
    check("mid_rst_clr_err", clr_err, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_buffsel", buffsel_draw, 0);
    check("mid_rst_ready", wr_ready, 0);
    rst = 0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
